// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the convolution layer engine.
package cnn_pkg;

  localparam int unsigned WidthDef = 16;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  // Accumulator width: full product plus headroom for every tap of a pixel.
  function automatic int unsigned acc_w(input int unsigned taps, input int unsigned width);
    return 2 * width + $clog2(taps);
  endfunction

  // Counter/address width that stays at least one bit wide.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/relu_sat_quant.sv
// Per-lane output quantiser: bias add, arithmetic shift, optional ReLU, signed saturation.
module relu_sat_quant
  import cnn_pkg::*;
#(
  parameter int unsigned AccW  = 33,
  parameter int unsigned Width = WidthDef,
  parameter int unsigned Frac  = 0,
  parameter int unsigned Relu  = 1
) (
  input  logic signed [AccW-1:0]    acc_i,
  input  logic signed [2*Width-1:0] bias_i,
  output logic signed [Width-1:0]   q_o
);

  localparam int unsigned SumW = AccW + 1;
  localparam logic signed [SumW-1:0] Max = SumW'(sat_max(Width));
  localparam logic signed [SumW-1:0] Min = SumW'(sat_min(Width));

  logic signed [SumW-1:0] sum;
  logic signed [SumW-1:0] shifted;

  always_comb begin
    sum     = {acc_i[AccW-1], acc_i} + {{(SumW-2*Width){bias_i[2*Width-1]}}, bias_i};
    shifted = sum >>> Frac;
    if ((Relu != 0) && shifted[SumW-1]) begin
      q_o = '0;
    end else if (shifted > Max) begin
      q_o = Max[Width-1:0];
    end else if (shifted < Min) begin
      q_o = Min[Width-1:0];
    end else begin
      q_o = shifted[Width-1:0];
    end
  end

endmodule

// File: rtl/conv_layer_engine.sv
// Streaming convolution engine: DSP_NO parallel MAC lanes fed one tap per accepted cycle,
// with per-pixel quantised output strobe and frame-complete tracking.
module conv_layer_engine
  import cnn_pkg::*;
#(
  parameter int unsigned WOUT       = 32,
  parameter int unsigned DSP_NO     = 128,
  parameter int unsigned WIDTH      = WidthDef,
  parameter int unsigned CHIN       = 32,
  parameter int unsigned KERNEL_DIM = 3,
  parameter int unsigned FRAC       = 14,
  parameter int unsigned RELU       = 1,
  localparam int unsigned Taps      = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int unsigned AddrW     = addr_w(Taps)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic                           restart_i,
  input  logic signed [WIDTH-1:0]        ifm_i,
  output logic [AddrW-1:0]               weight_addr_o,
  input  logic [DSP_NO-1:0][WIDTH-1:0]   kernels_i,
  input  logic [DSP_NO-1:0][2*WIDTH-1:0] bias_i,
  input  logic                           ram_feedback_i,
  output logic                           sample_o,
  output logic                           finish_o,
  output logic                           done_o,
  output logic [DSP_NO-1:0][WIDTH-1:0]   ofm_o
);

  localparam int unsigned AccW = acc_w(Taps, WIDTH);
  localparam int unsigned Npix = WOUT * WOUT;
  localparam int unsigned PixW = addr_w(Npix);

  state_e                  state_q;
  logic [AddrW-1:0]        tap_q;
  logic [PixW-1:0]         in_pix_q, out_pix_q;
  logic                    s1_valid_q, s1_first_q, s1_last_q;
  logic signed [WIDTH-1:0] s1_ifm_q;
  logic                    p_valid_q, p_first_q, p_last_q;
  logic                    acc_done_q, sample_q, done_q;
  logic                    accept, tap_last, in_last, out_last;

  assign accept   = en_i && (state_q == StRun) && !restart_i;
  assign tap_last = (tap_q == AddrW'(Taps - 1));
  assign in_last  = (in_pix_q == PixW'(Npix - 1));
  assign out_last = (out_pix_q == PixW'(Npix - 1));

  // Control FSM, counters and pipeline valid/flag shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      tap_q      <= '0;
      in_pix_q   <= '0;
      out_pix_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_ifm_q   <= '0;
      p_valid_q  <= 1'b0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      acc_done_q <= 1'b0;
      sample_q   <= 1'b0;
      done_q     <= 1'b0;
    end else if (restart_i) begin
      state_q    <= StRun;
      tap_q      <= '0;
      in_pix_q   <= '0;
      out_pix_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      p_valid_q  <= 1'b0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      acc_done_q <= 1'b0;
      sample_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_first_q <= accept && (tap_q == '0);
      s1_last_q  <= accept && tap_last;
      if (accept) s1_ifm_q <= ifm_i;
      p_valid_q  <= s1_valid_q;
      p_first_q  <= s1_first_q;
      p_last_q   <= s1_valid_q && s1_last_q;
      acc_done_q <= p_valid_q && p_last_q;
      sample_q   <= acc_done_q;
      if (accept) begin
        tap_q <= tap_last ? '0 : tap_q + AddrW'(1);
        if (tap_last) begin
          in_pix_q <= in_last ? '0 : in_pix_q + PixW'(1);
          if (in_last) state_q <= StDrain;
        end
      end
      // Final sample of the frame and the done flag share one edge.
      if (acc_done_q) begin
        out_pix_q <= out_last ? '0 : out_pix_q + PixW'(1);
        if (out_last) begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
      end
    end
  end

  for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
    logic signed [WIDTH-1:0]   ker_q;
    logic signed [2*WIDTH-1:0] prod_q;
    logic signed [AccW-1:0]    acc_q;
    logic signed [WIDTH-1:0]   ofm_q;
    logic signed [WIDTH-1:0]   quant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ker_q  <= '0;
        prod_q <= '0;
        acc_q  <= '0;
        ofm_q  <= '0;
      end else begin
        if (accept) ker_q <= kernels_i[l];
        if (s1_valid_q) prod_q <= (2*WIDTH)'(s1_ifm_q) * (2*WIDTH)'(ker_q);
        if (restart_i) begin
          acc_q <= '0;
        end else if (p_valid_q) begin
          acc_q <= (p_first_q ? '0 : acc_q) + AccW'(prod_q);
        end
        if (acc_done_q && !restart_i) ofm_q <= quant;
      end
    end

    relu_sat_quant #(
      .AccW  (AccW),
      .Width (WIDTH),
      .Frac  (FRAC),
      .Relu  (RELU)
    ) u_quant (
      .acc_i  (acc_q),
      .bias_i (bias_i[l]),
      .q_o    (quant)
    );

    assign ofm_o[l] = ofm_q;
  end

  assign weight_addr_o = tap_q;
  assign sample_o      = sample_q;
  assign finish_o      = sample_q && !ram_feedback_i;
  assign done_o        = done_q;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Scoreboard bench: three engine configurations share one stimulus stream and ROM model.
module tb_conv_layer_engine;

  localparam int Frame = 4;

  logic clk = 1'b0;
  logic rst_n, en, restart, ram_fb;
  logic signed [15:0] ifm;
  logic [1:0][31:0] bias;
  logic [1:0][1:0][15:0] rom;  // [tap][lane]
  logic [0:0] addr_a, addr_b, addr_c;
  logic [1:0][15:0] kern_a, kern_b, kern_c, ofm_a, ofm_b, ofm_c;
  logic sample_a, sample_b, sample_c, finish_a, finish_b, finish_c, done_a, done_b, done_c;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int pix_cnt = 0;
  bit rfb_en = 0;

  typedef struct {
    int               cyc;
    logic [1:0][15:0] oa, ob, oc;
    logic             done;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign kern_a = rom[addr_a];
  assign kern_b = rom[addr_b];
  assign kern_c = rom[addr_c];

  conv_layer_engine #(.WOUT(2), .DSP_NO(2), .WIDTH(16), .CHIN(2), .KERNEL_DIM(1),
                      .FRAC(0), .RELU(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .restart_i(restart), .ifm_i(ifm),
    .weight_addr_o(addr_a), .kernels_i(kern_a), .bias_i(bias), .ram_feedback_i(ram_fb),
    .sample_o(sample_a), .finish_o(finish_a), .done_o(done_a), .ofm_o(ofm_a));

  conv_layer_engine #(.WOUT(2), .DSP_NO(2), .WIDTH(16), .CHIN(2), .KERNEL_DIM(1),
                      .FRAC(0), .RELU(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .restart_i(restart), .ifm_i(ifm),
    .weight_addr_o(addr_b), .kernels_i(kern_b), .bias_i(bias), .ram_feedback_i(ram_fb),
    .sample_o(sample_b), .finish_o(finish_b), .done_o(done_b), .ofm_o(ofm_b));

  conv_layer_engine #(.WOUT(2), .DSP_NO(2), .WIDTH(16), .CHIN(2), .KERNEL_DIM(1),
                      .FRAC(2), .RELU(0)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .restart_i(restart), .ifm_i(ifm),
    .weight_addr_o(addr_c), .kernels_i(kern_c), .bias_i(bias), .ram_feedback_i(ram_fb),
    .sample_o(sample_c), .finish_o(finish_c), .done_o(done_c), .ofm_o(ofm_c));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference quantiser: floor-divide by 2**frac, then ReLU or signed 16-bit clamp.
  function automatic logic [15:0] quant(input longint sum, input int frac, input bit relu);
    longint s;
    s = sum >>> frac;
    if (relu && s < 0) return 16'h0000;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 1) == 1) return 16'($urandom);
    return 16'($urandom_range(0, 200) - 100);
  endfunction

  task automatic push_exp(input logic [15:0] a0, input logic [15:0] a1, input int at);
    exp_t e;
    longint s;
    for (int l = 0; l < 2; l++) begin
      s = longint'($signed(a0)) * longint'($signed(rom[0][l]))
        + longint'($signed(a1)) * longint'($signed(rom[1][l]))
        + longint'($signed(bias[l]));
      e.oa[l] = quant(s, 0, 1);
      e.ob[l] = quant(s, 0, 0);
      e.oc[l] = quant(s, 2, 0);
    end
    e.cyc  = at;
    e.done = (pix_cnt == Frame - 1);
    pix_cnt++;
    sbq.push_back(e);
  endtask

  task automatic step(input bit e, input logic [15:0] x);
    @(posedge clk);
    #1;
    en      = e;
    ifm     = x;
    restart = 1'b0;
    ram_fb  = rfb_en ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic chk_addr(input int exp);
    chk("weight_addr_a", addr_a, exp);
    chk("weight_addr_b", addr_b, exp);
    chk("weight_addr_c", addr_c, exp);
  endtask

  task automatic chk_done(input bit exp);
    chk("done_a", done_a, exp);
    chk("done_b", done_b, exp);
    chk("done_c", done_c, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'($urandom));
  endtask

  // Tap 0, optional stall, tap 1; the scoreboard expects the sample 3 edges after tap 1.
  task automatic drive_pixel(input logic [15:0] a0, input logic [15:0] a1,
                             input int stall, input bit push);
    step(1'b1, a0);
    chk_addr(0);
    for (int i = 0; i < stall; i++) begin
      step(1'b0, 16'($urandom));
      chk_addr(1);
    end
    step(1'b1, a1);
    chk_addr(1);
    if (push) push_exp(a0, a1, cyc + 1 + 3);
  endtask

  task automatic do_restart(input bit with_en);
    @(posedge clk);
    #1;
    restart = 1'b1;
    en      = with_en;
    ifm     = 16'($urandom);
    @(posedge clk);
    #1;
    restart = 1'b0;
    en      = 1'b0;
    pix_cnt = 0;
    chk_done(1'b0);
    chk_addr(0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_sample"}, {sample_a, sample_b, sample_c}, 0);
    chk({tag, "_finish"}, {finish_a, finish_b, finish_c}, 0);
    chk_done(1'b0);
    chk({tag, "_ofm_a"}, ofm_a, 0);
    chk({tag, "_ofm_b"}, ofm_b, 0);
    chk({tag, "_ofm_c"}, ofm_c, 0);
    chk_addr(0);
  endtask

  task automatic set_basic(input logic [31:0] b1);
    rom[0][0] = 16'd2;
    rom[1][0] = 16'd4;
    rom[0][1] = -16'sd2;
    rom[1][1] = -16'sd4;
    bias[0]   = 32'd1;
    bias[1]   = b1;
  endtask

  // Monitor: pops the scoreboard whenever any DUT presents a sample.
  initial forever begin
    @(negedge clk);
    if (sample_a || sample_b || sample_c) begin
      if (sbq.size() == 0) begin
        chk("unexpected_sample", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sample_all", {sample_a, sample_b, sample_c}, 3'b111);
        chk("sample_cycle", cyc, mon_e.cyc);
        chk("ofm_a", ofm_a, mon_e.oa);
        chk("ofm_b", ofm_b, mon_e.ob);
        chk("ofm_c", ofm_c, mon_e.oc);
        chk("done_at_sample", {done_a, done_b, done_c}, {3{mon_e.done}});
        chk("finish", {finish_a, finish_b, finish_c}, {3{~ram_fb}});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0][1:0][15:0] saved;

  initial begin
    rst_n = 1'b0; en = 1'b0; restart = 1'b0; ram_fb = 1'b0; ifm = '0;
    bias = '0; rom = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed frame: basic, saturation, shift, then the basic pixel with a 5-cycle stall.
    set_basic(32'd1);
    drive_pixel(16'd3, 16'd5, 0, 1);
    idle(4);
    rom[0] = {16'h8001, 16'h7fff};
    rom[1] = {16'h8001, 16'h7fff};
    bias   = '0;
    drive_pixel(16'h7fff, 16'h7fff, 0, 1);
    idle(4);
    set_basic(32'hffff_ffff);
    drive_pixel(16'd3, 16'd5, 0, 1);
    idle(4);
    set_basic(32'd1);
    drive_pixel(16'd3, 16'd5, 5, 1);
    idle(5);
    chk_done(1'b1);

    // Frame end at full rate, extra taps ignored, restart reproduces the frame.
    do_restart(1'b0);
    rfb_en = 1'b1;
    for (int p = 0; p < Frame; p++) saved[p] = {rnd16(), rnd16()};
    for (int p = 0; p < Frame; p++) drive_pixel(saved[p][0], saved[p][1], 0, 1);
    idle(4);
    chk_done(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, rnd16());
    idle(4);
    chk_done(1'b1);
    chk_addr(0);
    do_restart(1'b1);
    for (int p = 0; p < Frame; p++) drive_pixel(saved[p][0], saved[p][1], 0, 1);
    idle(5);
    chk_done(1'b1);

    // Restart while draining the last pixel drops its sample.
    do_restart(1'b0);
    for (int p = 0; p < Frame - 1; p++) drive_pixel(rnd16(), rnd16(), 0, 1);
    idle(4);
    drive_pixel(rnd16(), rnd16(), 0, 0);
    do_restart(1'b0);
    idle(6);

    // Asynchronous reset after one tap discards the partial pixel.
    rfb_en = 1'b0;
    step(1'b1, 16'd7);
    chk_addr(0);
    @(posedge clk);
    #1;
    en = 1'b0;
    ram_fb = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_quiet("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    pix_cnt = 0;
    idle(6);

    // Randomised frames with stalls, gaps and RAM back-pressure.
    rfb_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      rom = {rnd16(), rnd16(), rnd16(), rnd16()};
      for (int l = 0; l < 2; l++) begin
        bias[l] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
      end
      for (int p = 0; p < Frame; p++) begin
        drive_pixel(rnd16(), rnd16(), $urandom_range(0, 2), 1);
        idle($urandom_range(0, 2));
      end
      idle(5);
      chk_done(1'b1);
      do_restart(1'($urandom_range(0, 1)));
    end

    idle(10);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_layer_engine.md
# conv_layer_engine

Parametrised successor to the per-layer fire/expand convolution engines. It streams one input-feature-map value per accepted cycle into `DSP_NO` parallel MAC lanes and drives the address of an external weight ROM. Per output pixel it adds the lane bias, applies an arithmetic fractional shift, optional ReLU and saturation, and produces a one-cycle sample strobe. It also tolerates input stalls, counts pixels to the end of the frame, and can be restarted for the next frame without a reset.

## Interface
- `WOUT`, 32: output feature-map side; the frame is `WOUT**2` pixels.
- `DSP_NO`, 128: number of parallel MAC lanes (output channels).
- `WIDTH`, 16: pixel, weight and output width (signed).
- `CHIN`, 32: input channels.
- `KERNEL_DIM`, 3: kernel side; taps per pixel `T = KERNEL_DIM**2*CHIN`.
- `FRAC`, 14: arithmetic right shift applied after the bias add.
- `RELU`, 1: 1 clamps negative results to 0; 0 saturates signed.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  the `ifm` value is valid; one tap is accepted per cycle with `en=1`.
- `restart`  in  1  synchronous; clears counters, pipeline and `done` for a new frame.
- `ifm`  in  WIDTH  input pixel, signed.
- `weight_addr`  out  clog2(T)  ROM address, equal to the current tap index (combinational from the tap counter).
- `kernels`  in  DSP_NO x WIDTH  ROM data for `weight_addr`, valid in the same cycle.
- `bias`  in  DSP_NO x 2*WIDTH  per-lane bias, static for the frame.
- `ram_feedback`  in  1  output RAM busy.
- `sample`  out  1  one-cycle strobe; `ofm` is valid in that cycle.
- `finish`  out  1  `sample && !ram_feedback`.
- `done`  out  1  sticky frame-complete flag.
- `ofm`  out  DSP_NO x WIDTH  quantised outputs, held until the next sample.

## Operation
- States:
  - RUN: accepts taps.
  - DRAIN: the last pixel's final tap has been accepted; `en` is ignored while the pipeline empties.
  - DONE: `done=1`; `en` is ignored.
- Transitions:
  - `restart` from any state goes to RUN and clears everything except `ofm`.
  - RUN goes to DRAIN when the final tap of pixel `WOUT**2-1` is accepted.
  - DRAIN goes to DONE on the edge that issues the last `sample`.
- Tap counter:
  - 0..T-1, advances only on accepted taps and wraps to 0 after T-1.
  - `en=0` freezes it and the accumulators (a stall).
- Pipeline:
  - Stage 1 registers `ifm`, `kernels`, valid, first-tap and last-tap flags.
  - Stage 2 computes `acc <= (first ? 0 : acc) + pix*ker` per lane.
  - `acc` is `2*WIDTH+clog2(T)` bits, signed; no overflow is possible.
- Output stage (after the last tap reaches `acc`):
  - `s = (acc + sext(bias)) >>> FRAC`.
  - If `RELU` and `s<0`: the result is 0.
  - Otherwise saturate: above `2**(WIDTH-1)-1` gives max, below `-2**(WIDTH-1)` gives min, else the low `WIDTH` bits.
- Pixel counter increments on each `sample`.
- Simultaneous events:
  - `restart` together with `en`: `restart` wins and the tap is discarded.
  - `restart` during DRAIN: in-flight results are dropped and no `sample` is issued.

## Timing
- Reset values:
  - `sample`=0, `finish`=0 (with `ram_feedback`=0), `done`=0, `ofm`=all 0, `weight_addr`=0.
  - State RUN; counters and accumulators 0.
- Latency: the final tap of a pixel is accepted at edge e; `acc` is complete at e+2; `ofm` and `sample` are registered at e+3.
- Back-to-back pixels at full rate: a `sample` every T cycles. The next pixel's first tap may be accepted at e+1 with no bubble.
- `done` rises on the same edge as the final `sample` and stays high until `restart` or reset.
- `finish` is combinational from `sample` and `ram_feedback`.
- Reset mid-pixel: all partial sums are lost, with no `sample`.

## Structure
- `cnn_pkg`: `WIDTH` default, accumulator width function `acc_w(T,WIDTH)`, state enum `{RUN, DRAIN, DONE}`, and saturation limits.
- Sub-module `relu_sat_quant`: purely combinational, per lane; inputs acc, bias, `FRAC`, `RELU`; output `WIDTH` bits. It is instantiated `DSP_NO` times.
- The MAC accumulate is inline in a generate loop; the ROM stays outside the block.

## Test plan
Unless a test says otherwise: `DSP_NO=2`, `KERNEL_DIM=1`, `CHIN=2`, `WOUT=2`, `FRAC=0`.
- Basic MAC, `RELU=1`: `ifm` 3,5; lane0 kernels 2,4 with bias 1; lane1 kernels -2,-4 with bias 1. Expect `ofm0=27`, `ofm1=0`, `sample` 3 edges after the second tap.
- Saturation, `RELU=0`: `ifm` 0x7FFF twice with kernels 0x7FFF gives `ofm=0x7FFF`. With kernels 0x8001 the result is 0x8000.
- Shift, `FRAC=2`: sum 27 gives 6; sum -27 with `RELU=0` gives -7.
- Stall: insert 5 cycles of `en=0` between the two taps. Expect the same `ofm` and `sample` delayed by exactly 5 cycles; `weight_addr` holds during the stall.
- Frame end:
  - 4 pixels at full rate give 4 samples; `done` rises with the 4th.
  - Further `en` gives no `sample`.
  - `restart` clears `done`, and the next frame reproduces the results.
- Reset and feedback:
  - Assert `rst` low after one tap: no `sample`, and all outputs return to their reset values.
  - `ram_feedback=1` during a `sample`: `finish=0` while `sample=1`.
